// File: rtl/spi_shift.sv
// Serial shift engine of the SPI master: drives mosi and samples miso on the clgen edge strobes.
// Optional feature macro: SPI_SHIFT_LOOPBACK_EN adds a loopback input that feeds mosi back into rx.
module spi_shift #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic              wb_clk,
  input  logic              wb_reset_n,
  input  logic              go,
  input  logic [LEN_W-1:0]  len,
  input  logic              lsb,
  input  logic              tx_negedge,
  input  logic              rx_negedge,
  input  logic              cpol_0,
  input  logic              cpol_1,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
`ifdef SPI_SHIFT_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              tip,
  output logic              lstclk,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              done
);

  localparam logic [LEN_W:0] NMAX = (LEN_W+1)'(DATA_W);

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [LEN_W:0]      n_q, n_d;
  logic                lsb_q, lsb_d;
  logic                tx_neg_q, tx_neg_d;
  logic                rx_neg_q, rx_neg_d;
  logic [LEN_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic [LEN_W:0]      rx_cnt_q, rx_cnt_d;
  logic                mosi_q, mosi_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                done_q, done_d;

  logic [LEN_W:0]      n_sel, first_idx, tx_idx, rx_idx;
  logic                tx_edge, rx_edge, rx_bit, last_rx;

  // Edge selection uses the modes latched at go, so mid-transfer changes are ignored.
  assign tx_edge   = tx_neg_q ? cpol_1 : cpol_0;
  assign rx_edge   = rx_neg_q ? cpol_1 : cpol_0;
  assign n_sel     = (len == '0) ? NMAX : {1'b0, len};
  assign first_idx = n_sel - (LEN_W+1)'(1);
  assign tx_idx    = lsb_q ? (n_q - {1'b0, tx_cnt_q}) : ({1'b0, tx_cnt_q} - (LEN_W+1)'(1));
  assign rx_idx    = n_q - rx_cnt_q;
  assign last_rx   = rx_edge && (rx_cnt_q == (LEN_W+1)'(1));

`ifdef SPI_SHIFT_LOOPBACK_EN
  assign rx_bit = loopback ? mosi_q : miso;
`else
  assign rx_bit = miso;
`endif

  always_ff @(posedge wb_clk or negedge wb_reset_n) begin
    if (!wb_reset_n) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      n_q       <= '0;
      lsb_q     <= 1'b0;
      tx_neg_q  <= 1'b0;
      rx_neg_q  <= 1'b0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      mosi_q    <= 1'b0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      n_q       <= n_d;
      lsb_q     <= lsb_d;
      tx_neg_q  <= tx_neg_d;
      rx_neg_q  <= rx_neg_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      mosi_q    <= mosi_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = XFER;
      XFER:    if (last_rx) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d      = tx_q;
    n_d       = n_q;
    lsb_d     = lsb_q;
    tx_neg_d  = tx_neg_q;
    rx_neg_d  = rx_neg_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    mosi_d    = mosi_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    if (state_q == IDLE) begin
      if (go) begin
        tx_d      = tx_data;
        n_d       = n_sel;
        lsb_d     = lsb;
        tx_neg_d  = tx_negedge;
        rx_neg_d  = rx_negedge;
        mosi_d    = lsb ? tx_data[0] : tx_data[first_idx[LEN_W-1:0]];
        tx_cnt_d  = first_idx[LEN_W-1:0];
        rx_cnt_d  = n_sel;
        rx_data_d = '0;
      end
    end else begin
      if (tx_edge && (tx_cnt_q != '0)) begin
        mosi_d   = tx_q[tx_idx[LEN_W-1:0]];
        tx_cnt_d = tx_cnt_q - LEN_W'(1);
      end
      // rx_bit comes from registers, so a shared edge captures the pre-edge mosi.
      if (rx_edge) begin
        if (lsb_q) rx_data_d[rx_idx[LEN_W-1:0]] = rx_bit;
        else       rx_data_d = {rx_data_q[DATA_W-2:0], rx_bit};
        rx_cnt_d = rx_cnt_q - (LEN_W+1)'(1);
        done_d   = last_rx;
      end
    end
  end

  always_comb begin
    tip     = (state_q == XFER);
    lstclk  = tip && (tx_cnt_q == '0);
    mosi    = mosi_q;
    rx_data = rx_data_q;
    done    = done_q;
  end

endmodule
